// File: rtl/exec_unit.sv
// Single-issue execute stage: reads up to two registers, computes an 8-bit
// result with zero/carry flags and writes it back through the register file.
module exec_unit #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [3:0]        op_code,
   input  logic [ADDR_W-1:0] op_dst,
   input  logic [ADDR_W-1:0] op_src0,
   input  logic [ADDR_W-1:0] op_src1,
   input  logic [DATA_W-1:0] op_imm,
   output logic              rd0_enable,
   output logic [ADDR_W-1:0] rd0_addr,
   input  logic [DATA_W-1:0] rd0_data,
   output logic              rd1_enable,
   output logic [ADDR_W-1:0] rd1_addr,
   input  logic [DATA_W-1:0] rd1_data,
   output logic              wr_enable,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              flag_z,
   output logic              flag_c,
   output logic              done,
   output logic              illegal
);

   localparam int unsigned CNT_W = 3;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_EXEC  = 3'd2;
   localparam logic [2:0] S_SHIFT = 3'd3;
   localparam logic [2:0] S_WRITE = 3'd4;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_MOVI = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_SHL  = 4'd7;
   localparam logic [3:0] OP_CMP  = 4'd8;

   logic [2:0]        state_q, state_d;
   logic [3:0]        code_q, code_d;
   logic [ADDR_W-1:0] dst_q, dst_d, src0_q, src0_d, src1_q, src1_d;
   logic [DATA_W-1:0] imm_q, imm_d, res_q, res_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              fz_q, fz_d, fc_q, fc_d;
   logic              rd0_en_q, rd0_en_d, rd1_en_q, rd1_en_d;
   logic [ADDR_W-1:0] rd0_addr_q, rd0_addr_d, rd1_addr_q, rd1_addr_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              done_q, done_d, ill_q, ill_d;

   logic [DATA_W-1:0] opa, opb, result, shl;
   logic [DATA_W:0]   sum, diff;
   logic              fin;

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d    = state_q;
      code_d     = code_q;
      dst_d      = dst_q;
      src0_d     = src0_q;
      src1_d     = src1_q;
      imm_d      = imm_q;
      res_d      = res_q;
      cnt_d      = cnt_q;
      fz_d       = fz_q;
      fc_d       = fc_q;
      rd0_en_d   = 1'b0;
      rd0_addr_d = '0;
      rd1_en_d   = 1'b0;
      rd1_addr_d = '0;
      wr_en_d    = 1'b0;
      wr_addr_d  = '0;
      wr_data_d  = '0;
      done_d     = 1'b0;
      ill_d      = 1'b0;
      fin        = 1'b0;
      result     = res_q;
      opa        = rd0_data;
      opb        = (code_q == OP_ADDI) ? imm_q : rd1_data;
      sum        = {1'b0, opa} + {1'b0, opb};
      diff       = {1'b0, opa} - {1'b0, opb};
      shl        = {res_q[DATA_W-2:0], 1'b0};

      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               code_d = op_code;
               dst_d  = op_dst;
               src0_d = op_src0;
               src1_d = op_src1;
               imm_d  = op_imm;
               if (op_code == OP_MOVI) begin
                  state_d   = S_WRITE;
                  wr_en_d   = 1'b1;
                  wr_addr_d = op_dst;
                  wr_data_d = op_imm;
                  done_d    = 1'b1;
               end else begin
                  state_d    = S_READ;
                  rd0_en_d   = 1'b1;
                  rd0_addr_d = op_src0;
                  if (op_code != OP_ADDI) begin
                     rd1_en_d   = 1'b1;
                     rd1_addr_d = op_src1;
                  end
               end
            end
         end
         S_READ: state_d = S_EXEC;
         S_EXEC: begin
            fin = 1'b1;
            case (code_q)
               OP_ADD, OP_ADDI: begin
                  result = sum[DATA_W-1:0];
                  fc_d   = sum[DATA_W];
                  fz_d   = (result == '0);
               end
               OP_SUB, OP_CMP: begin
                  result = diff[DATA_W-1:0];
                  fc_d   = diff[DATA_W];
                  fz_d   = (result == '0);
               end
               OP_AND: begin
                  result = opa & opb;
                  fz_d   = (result == '0);
               end
               OP_OR: begin
                  result = opa | opb;
                  fz_d   = (result == '0);
               end
               OP_XOR: begin
                  result = opa ^ opb;
                  fz_d   = (result == '0);
               end
               OP_SHL: begin
                  result = opa;
                  if (opb[CNT_W-1:0] != '0) begin
                     fin     = 1'b0;
                     cnt_d   = opb[CNT_W-1:0];
                     state_d = S_SHIFT;
                  end else begin
                     fc_d = 1'b0;
                     fz_d = (opa == '0);
                  end
               end
               default: ;
            endcase
            res_d = result;
         end
         S_SHIFT: begin
            // Carry only reflects the last bit shifted out
            res_d = shl;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               fin    = 1'b1;
               result = shl;
               fc_d   = res_q[DATA_W-1];
               fz_d   = (shl == '0);
            end
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (fin) begin
         state_d = S_WRITE;
         done_d  = 1'b1;
         ill_d   = (code_q > OP_CMP);
         if ((code_q != OP_CMP) && (code_q <= OP_SHL)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = dst_q;
            wr_data_d = result;
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         code_q     <= '0;
         dst_q      <= '0;
         src0_q     <= '0;
         src1_q     <= '0;
         imm_q      <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
         fz_q       <= 1'b0;
         fc_q       <= 1'b0;
         rd0_en_q   <= 1'b0;
         rd0_addr_q <= '0;
         rd1_en_q   <= 1'b0;
         rd1_addr_q <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         code_q     <= code_d;
         dst_q      <= dst_d;
         src0_q     <= src0_d;
         src1_q     <= src1_d;
         imm_q      <= imm_d;
         res_q      <= res_d;
         cnt_q      <= cnt_d;
         fz_q       <= fz_d;
         fc_q       <= fc_d;
         rd0_en_q   <= rd0_en_d;
         rd0_addr_q <= rd0_addr_d;
         rd1_en_q   <= rd1_en_d;
         rd1_addr_q <= rd1_addr_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
         ill_q      <= ill_d;
      end
   end

   assign op_ready   = (state_q == S_IDLE);
   assign rd0_enable = rd0_en_q;
   assign rd0_addr   = rd0_addr_q;
   assign rd1_enable = rd1_en_q;
   assign rd1_addr   = rd1_addr_q;
   assign wr_enable  = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign flag_z     = fz_q;
   assign flag_c     = fc_q;
   assign done       = done_q;
   assign illegal    = ill_q;

endmodule

// File: doc/exec_unit.md
# exec_unit

Single-issue execute stage sitting directly upstream of `register_file`. Accepts one decoded operation at a time over a valid/ready handshake. Reads up to two source registers through the register file's two read ports, computes an 8-bit result plus zero/carry flags, and writes the result back through the register file's write port. It is the only master of all three register-file ports.

## Interface
- `DATA_W`, 8, datapath and register width
- `ADDR_W`, 3, register address width (8 registers)
- `clk` input 1: single clock; all state updates on the rising edge
- `reset_n` input 1: asynchronous, active-low reset
- `op_valid` input 1: decoded operation present
- `op_ready` output 1: unit idle and able to accept; equals (state == IDLE)
- `op_code` input 4: operation select
- `op_dst` input `ADDR_W`: destination register
- `op_src0` input `ADDR_W`: first source register
- `op_src1` input `ADDR_W`: second source register
- `op_imm` input `DATA_W`: immediate value
- `rd0_enable` / `rd0_addr` output 1 / `ADDR_W`: register file read port 0
- `rd0_data` input `DATA_W`: read port 0 data
- `rd1_enable` / `rd1_addr` output 1 / `ADDR_W`: register file read port 1
- `rd1_data` input `DATA_W`: read port 1 data
- `wr_enable` / `wr_addr` / `wr_data` output 1 / `ADDR_W` / `DATA_W`: register file write port
- `flag_z` output 1: zero flag
- `flag_c` output 1: carry/borrow flag
- `done` output 1: one-cycle pulse when an operation retires
- `illegal` output 1: one-cycle pulse when an undefined opcode retires

## Operation
- Opcodes:
  - 0 ADD: src0+src1
  - 1 SUB: src0−src1
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 MOVI: dst=imm, no reads
  - 6 ADDI: src0+imm
  - 7 SHL: src0 shifted left by src1[2:0]
  - 8 CMP: src0−src1, flags only, no write
  - 9–15: illegal
- FSM states: IDLE, READ, EXEC, SHIFT, WRITE.
  - IDLE → READ on accept. MOVI goes IDLE → WRITE.
  - READ → EXEC, always.
  - EXEC → SHIFT if SHL with count ≠ 0; otherwise → WRITE.
  - SHIFT → SHIFT until the count reaches 0, then → WRITE.
  - WRITE → IDLE.
- Accept: `op_valid && op_ready` at a rising edge. All op fields are latched at that edge. Inputs are ignored in every other state.
- READ: `rd0_enable=1`, `rd0_addr=src0`; `rd1_enable=1`, `rd1_addr=src1`. ADDI drives only port 0. Register file read data is valid in the cycle after the enable (EXEC); the unit captures it there.
- Arithmetic is 9-bit internally: result = sum[7:0].
  - ADD/ADDI: `flag_c` = sum[8].
  - SUB/CMP: `flag_c` = 1 iff src0 < src1 (borrow), unsigned.
  - `flag_z` = (result == 0) for ADD, SUB, ADDI, CMP, AND, OR, XOR, SHL.
  - Logic ops leave `flag_c` unchanged. MOVI and illegal ops leave both flags unchanged.
- SHL: one bit per SHIFT cycle. `flag_c` takes the bit shifted out. Count 0 → result = src0 with `flag_c` cleared. The flags reflect the final value on entry to WRITE.
- WRITE, held for exactly one cycle:
  - `wr_enable=1`, `wr_addr=dst`, `wr_data=result`, `done=1`.
  - CMP and illegal: `wr_enable=0`. `done=1` is still asserted; illegal also asserts `illegal=1`.
- Read and write enables are never high in the same cycle.
- All outputs except `op_ready` are registered.

## Timing
- Reset (asynchronous, `reset_n` low):
  - State = IDLE.
  - All enables, addresses, `wr_data`, `flag_z`, `flag_c`, `done`, `illegal` = 0.
  - `op_ready` = 1, but no accept occurs while `reset_n` is low.
- Reset mid-operation aborts immediately with no partial write. A write already pulsed is not undone.
- Latency from accept edge to WRITE cycle:
  - ALU ops and CMP: 3 cycles (READ, EXEC, WRITE).
  - MOVI: 1 cycle.
  - SHL: 3+n cycles, where n = count.
- `op_ready` returns high in the cycle after WRITE. Back-to-back throughput is one op per 4 cycles (ALU).
- A dependent op issued next sees the written value: the write commits at the WRITE→IDLE edge, before the following READ.
- `op_valid` held high during busy is not lost; it is accepted on return to IDLE.

## Test plan
- Reset mid-stream: assert `reset_n`=0 during the SHIFT state → no `wr_enable` pulse; all outputs 0; `op_ready`=1 after release.
- MOVI r3,42, then ADD r4,r3,r3 → `wr_enable` pulses with r3=42, then r4=84; z=0, c=0; ADD `done` arrives 3 cycles after its accept edge.
- ADDI r5,r3(200),imm 100 → r5=44, c=1, z=0. SUB r6,r5(44),r5 → r6=0, z=1, c=0. CMP r3(10) vs r5(20) → no write, c=1, z=0, `done` pulses.
- SHL r1(0xC1) by r2=2 → `wr_data`=0x04, c=1, 5 cycles to `done`. Count 0 with r2=8 → r1 unchanged, c=0, 3 cycles to `done`.
- Opcode 12 → `illegal` and `done` pulse together, no write, flags unchanged; the next op is accepted normally.
- `op_valid` held high across 4 queued ops → each accepted only when `op_ready`=1; read enables and `wr_enable` are never concurrent (assertion).
